// File: rtl/cellrv32_dmem_bridge.sv
// cellrv32_dmem_bridge: CPU load/store request stage to DMEM with ticketed strobes and ack timeout (optional CELLRV32_DMEM_BRIDGE_ALIGN_CHK_EN)
module cellrv32_dmem_bridge #(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [3:0]        req_ben_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_data_o,
    output logic              rsp_err_o,
    output logic              dmem_rden_o,
    output logic              dmem_wren_o,
    output logic [3:0]        dmem_ben_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [31:0]       dmem_data_o,
    output logic [3:0]        dmem_ticket_o,
    input  logic [31:0]       dmem_data_i,
    input  logic [3:0]        dmem_ticket_i,
    input  logic              dmem_ack_i,
    input  logic              dmem_err_i
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam int CNT_W = $clog2(TIMEOUT);

    state_t              state_q, state_d;
    logic                we_q;
    logic [3:0]          ben_q;
    logic [31:0]         wdata_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          ticket_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [31:0]         rsp_data_q;
    logic                rsp_err_q;
    logic                match, timeout, align_ok, accept;

    assign accept  = (state_q == IDLE) && req_valid_i;
    assign match   = (dmem_ack_i | dmem_err_i) && (dmem_ticket_i == ticket_q);
    assign timeout = cnt_q == CNT_W'(TIMEOUT - 1);

`ifdef CELLRV32_DMEM_BRIDGE_ALIGN_CHK_EN
    assign align_ok = (req_ben_i == (4'b0001 << req_addr_i[1:0])) ||
                      (req_ben_i == 4'b0011 && req_addr_i[1:0] == 2'b00) ||
                      (req_ben_i == 4'b1100 && req_addr_i[1:0] == 2'b10) ||
                      (req_ben_i == 4'b1111 && req_addr_i[1:0] == 2'b00);
`else
    assign align_ok = 1'b1;
`endif

    // transaction sequencing: accept, one strobe cycle, wait for ack, one response cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = align_ok ? ISSUE : RESP;
            ISSUE:   state_d = WAIT;
            WAIT:    if (match || timeout) state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // request capture, response latching, timeout and ticket counters
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            we_q       <= 1'b0;
            ben_q      <= '0;
            wdata_q    <= '0;
            addr_q     <= '0;
            ticket_q   <= 4'd1;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (accept && align_ok) begin
                we_q    <= req_we_i;
                ben_q   <= req_ben_i;
                wdata_q <= req_wdata_i;
                addr_q  <= req_addr_i;
            end else if (accept) begin
                rsp_err_q  <= 1'b1;
                rsp_data_q <= '0;
            end
            cnt_q <= (state_q == WAIT) ? cnt_q + 1'b1 : '0;
            if (state_q == WAIT && match) begin
                rsp_err_q  <= dmem_err_i;
                rsp_data_q <= (!we_q && !dmem_err_i) ? dmem_data_i : '0;
            end else if (state_q == WAIT && timeout) begin
                rsp_err_q  <= 1'b1;
                rsp_data_q <= '0;
            end
            if (state_q == RESP) ticket_q <= (ticket_q == 4'd15) ? 4'd1 : ticket_q + 4'd1;
        end
    end

    assign req_ready_o   = state_q == IDLE;
    assign rsp_valid_o   = state_q == RESP;
    assign rsp_data_o    = rsp_data_q;
    assign rsp_err_o     = rsp_err_q;
    assign dmem_rden_o   = (state_q == ISSUE) && !we_q;
    assign dmem_wren_o   = (state_q == ISSUE) && we_q;
    assign dmem_ben_o    = (state_q == ISSUE) ? ben_q : 4'd0;
    assign dmem_data_o   = (state_q == ISSUE && we_q) ? wdata_q : 32'd0;
    assign dmem_addr_o   = addr_q;
    assign dmem_ticket_o = ticket_q;
endmodule

// File: tb/tb_cellrv32_dmem_bridge.sv
// tb_cellrv32_dmem_bridge: timeline-model self-checking bench for cellrv32_dmem_bridge
module tb_cellrv32_dmem_bridge;
    localparam int TMO = 16;
    localparam int N   = 4096;
`ifdef CELLRV32_DMEM_BRIDGE_ALIGN_CHK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk_i = 1'b0, rstn_i = 1'b0;
    logic        req_valid_i = 1'b0, req_we_i = 1'b0;
    logic [31:0] req_addr_i = '0, req_wdata_i = '0;
    logic [3:0]  req_ben_i = '0;
    logic        req_ready_o, rsp_valid_o, rsp_err_o, dmem_rden_o, dmem_wren_o;
    logic [31:0] rsp_data_o, dmem_addr_o, dmem_data_o;
    logic [3:0]  dmem_ben_o, dmem_ticket_o;
    logic [31:0] dmem_data_i = '0;
    logic [3:0]  dmem_ticket_i = '0;
    logic        dmem_ack_i = 1'b0, dmem_err_i = 1'b0;

    cellrv32_dmem_bridge #(.TIMEOUT(TMO), .ADDR_W(32)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_ben_i(req_ben_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .dmem_rden_o(dmem_rden_o), .dmem_wren_o(dmem_wren_o), .dmem_ben_o(dmem_ben_o),
        .dmem_addr_o(dmem_addr_o), .dmem_data_o(dmem_data_o), .dmem_ticket_o(dmem_ticket_o),
        .dmem_data_i(dmem_data_i), .dmem_ticket_i(dmem_ticket_i),
        .dmem_ack_i(dmem_ack_i), .dmem_err_i(dmem_err_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // expected timeline, indexed by cycle number
    bit          exp_ready [N];
    bit          exp_st    [N];
    bit          exp_we    [N];
    bit          exp_rv    [N];
    bit          exp_rerr  [N];
    logic [3:0]  exp_ben   [N];
    logic [3:0]  exp_tkt   [N];
    logic [31:0] exp_dat   [N];
    logic [31:0] exp_addr  [N];
    logic [31:0] exp_rdata [N];

    int n_cmp = 0, n_bad = 0;
    int m_tkt = 1;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // per-cycle compare against the timeline; observed strobe/response bookkeeping
    logic [31:0] hold_d = '0, hold_a = '0;
    bit          hold_e = 1'b0, saw_zero = 1'b0;
    int          st_cyc = -1, rv_cyc = -1;
    logic [3:0]  last_tkt = '0;
    always @(negedge clk_i) begin
        if (!rstn_i) begin
            hold_d = '0; hold_e = 1'b0; hold_a = '0;
        end
        if (chk_en && cyc < N) begin
            if (exp_rv[cyc]) begin hold_d = exp_rdata[cyc]; hold_e = exp_rerr[cyc]; end
            if (exp_st[cyc]) hold_a = exp_addr[cyc];
            chk("req_ready", 32'(req_ready_o), 32'(exp_ready[cyc]));
            chk("dmem_rden", 32'(dmem_rden_o), 32'(exp_st[cyc] && !exp_we[cyc]));
            chk("dmem_wren", 32'(dmem_wren_o), 32'(exp_st[cyc] && exp_we[cyc]));
            chk("dmem_ben", 32'(dmem_ben_o), 32'(exp_st[cyc] ? exp_ben[cyc] : 4'd0));
            chk("dmem_data", dmem_data_o, (exp_st[cyc] && exp_we[cyc]) ? exp_dat[cyc] : 32'd0);
            chk("dmem_addr", dmem_addr_o, hold_a);
            chk("rsp_valid", 32'(rsp_valid_o), 32'(exp_rv[cyc]));
            chk("rsp_data", rsp_data_o, hold_d);
            chk("rsp_err", 32'(rsp_err_o), 32'(hold_e));
            if (exp_st[cyc]) chk("dmem_ticket", 32'(dmem_ticket_o), 32'(exp_tkt[cyc]));
        end
        if (dmem_rden_o || dmem_wren_o) begin
            st_cyc = cyc;
            last_tkt = dmem_ticket_o;
            if (dmem_ticket_o == 4'd0) saw_zero = 1'b1;
        end
        if (rsp_valid_o) rv_cyc = cyc;
    end

    function automatic bit legal(input logic [31:0] addr, input logic [3:0] ben);
        logic [3:0] one;
        one = 4'b0001;
        return (ben == (one << addr[1:0])) ||
               (ben == 4'b0011 && addr[1:0] == 2'b00) ||
               (ben == 4'b1100 && addr[1:0] == 2'b10) ||
               (ben == 4'b1111 && addr[1:0] == 2'b00);
    endfunction

    function automatic logic [3:0] prev_tkt(input int t);
        return 4'(t == 1 ? 15 : t - 1);
    endfunction

    // one transaction; ack_k = WAIT-cycle index of the matching ack (-1: never), stale_k = index of a stale-ticket ack
    task automatic txn(input bit we, input logic [31:0] addr, input logic [3:0] ben, input logic [31:0] wd,
                       input int ack_k, input bit ack_e, input logic [31:0] rd, input int stale_k);
        int a, s, r, k, t;
        bit ok, hit;
        a   = cyc;
        t   = m_tkt;
        ok  = !ALIGN || legal(addr, ben);
        hit = ack_k >= 0 && ack_k < TMO;
        s   = a + 1;
        r   = !ok ? s : hit ? s + 2 + ack_k : s + 1 + TMO;
        for (int c = s; c <= r; c++) exp_ready[c] = 1'b0;
        if (ok) begin
            exp_st[s] = 1'b1; exp_we[s] = we; exp_ben[s] = ben; exp_dat[s] = wd;
            exp_addr[s] = addr; exp_tkt[s] = 4'(t);
        end
        exp_rv[r]    = 1'b1;
        exp_rerr[r]  = !ok || !hit || ack_e;
        exp_rdata[r] = (ok && hit && !we && !ack_e) ? rd : 32'd0;
        m_tkt = (m_tkt == 15) ? 1 : m_tkt + 1;
        req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_ben_i = ben; req_wdata_i = wd;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0; req_we_i = 1'($urandom); req_addr_i = $urandom;
        req_ben_i = 4'($urandom); req_wdata_i = $urandom;
        while (cyc < r) begin
            k = cyc - s - 1;
            dmem_ack_i = 1'b0; dmem_err_i = 1'b0; dmem_ticket_i = '0; dmem_data_i = $urandom;
            if (ok && k >= 0) begin
                if (k == ack_k) begin
                    dmem_ack_i = 1'b1; dmem_err_i = ack_e; dmem_ticket_i = 4'(t); dmem_data_i = rd;
                end else if (k == stale_k) begin
                    dmem_ack_i = 1'b1; dmem_err_i = 1'($urandom); dmem_ticket_i = prev_tkt(t);
                end
            end
            @(posedge clk_i); #1;
        end
        dmem_ack_i = 1'b0; dmem_err_i = 1'b0; dmem_ticket_i = '0;
        @(posedge clk_i); #1;
    endtask

    // idle cycles with acks carrying the current ticket, which must have no effect
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            dmem_ack_i = 1'b1; dmem_err_i = 1'($urandom); dmem_ticket_i = 4'(m_tkt); dmem_data_i = $urandom;
            req_addr_i = $urandom; req_wdata_i = $urandom;
            @(posedge clk_i); #1;
        end
        dmem_ack_i = 1'b0; dmem_err_i = 1'b0; dmem_ticket_i = '0;
    endtask

    task automatic reset_checks;
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rden", 32'(dmem_rden_o), 32'd0);
        chk("rst_wren", 32'(dmem_wren_o), 32'd0);
        chk("rst_ben", 32'(dmem_ben_o), 32'd0);
        chk("rst_dmem_data", dmem_data_o, 32'd0);
        chk("rst_addr", dmem_addr_o, 32'd0);
        chk("rst_rsp_data", rsp_data_o, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
    endtask

    initial begin
        int a, t0, rv_before;
        for (int i = 0; i < N; i++) exp_ready[i] = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        reset_checks();
        rstn_i = 1'b1;
        chk_en = 1'b1;
        idle(2);

        txn(0, 32'h10, 4'hF, 32'h0, 0, 0, 32'hDEADBEEF, -1);
        chk("read_data", rsp_data_o, 32'hDEADBEEF);
        chk("read_err", 32'(rsp_err_o), 32'd0);
        chk("read_ticket", 32'(last_tkt), 32'd1);
        chk("read_latency", 32'(rv_cyc - st_cyc), 32'd2);

        txn(1, 32'h20, 4'h3, 32'h12345678, 0, 0, 32'hFFFFFFFF, -1);
        chk("write_data", rsp_data_o, 32'd0);
        chk("write_ticket", 32'(last_tkt), 32'd2);

        txn(0, 32'h44, 4'hF, 32'h0, -1, 0, 32'h0, -1);
        chk("timeout_latency", 32'(rv_cyc - st_cyc), 32'(TMO + 1));
        chk("timeout_err", 32'(rsp_err_o), 32'd1);

        txn(0, 32'h48, 4'hF, 32'h0, TMO - 1, 0, 32'hCAFE0001, -1);
        chk("late_match_err", 32'(rsp_err_o), 32'd0);
        chk("late_match_data", rsp_data_o, 32'hCAFE0001);

        txn(0, 32'h4C, 4'hF, 32'h0, 2, 1, 32'hAAAA5555, 0);
        chk("err_wins_data", rsp_data_o, 32'd0);
        chk("err_wins_err", 32'(rsp_err_o), 32'd1);

        txn(0, 32'h56, 4'b0100, 32'h0, 3, 0, 32'h000000A5, 1);
        chk("stale_ticket", 32'(last_tkt), 32'd6);
        chk("stale_data", rsp_data_o, 32'h000000A5);

        txn(1, 32'h50, 4'b0001, 32'h55, 0, 1, 32'h77777777, -1);
        idle(3);

        t0 = cyc;
        for (int i = 0; i < 16; i++) begin
            txn(1'(i), 32'h100 + 32'(4 * i), 4'hF, 32'h1000 + 32'(i), 0, 0, 32'hB000 + 32'(i), -1);
            if (i == 7) chk("wrap_tkt15", 32'(last_tkt), 32'd15);
            if (i == 8) chk("wrap_tkt1", 32'(last_tkt), 32'd1);
        end
        chk("throughput_cycles", 32'(cyc - t0), 32'd64);
        chk("final_ticket", 32'(last_tkt), 32'd8);

        rv_before = rv_cyc;
        a = cyc;
        exp_ready[a + 1] = 1'b0; exp_ready[a + 2] = 1'b0;
        exp_st[a + 1] = 1'b1; exp_we[a + 1] = 1'b0; exp_ben[a + 1] = 4'hF;
        exp_addr[a + 1] = 32'h300; exp_tkt[a + 1] = 4'(m_tkt);
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h300; req_ben_i = 4'hF;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        @(posedge clk_i); #1;
        #2 chk_en = 1'b0; rstn_i = 1'b0;
        #1 reset_checks();
        m_tkt = 1;
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        chk_en = 1'b1;
        idle(4);
        chk("no_rsp_after_reset", 32'(rv_cyc), 32'(rv_before));
        txn(0, 32'h304, 4'hF, 32'h0, 1, 0, 32'h13572468, -1);
        chk("post_reset_ticket", 32'(last_tkt), 32'd1);

        if (ALIGN) begin
            t0 = st_cyc;
            txn(0, 32'h202, 4'hF, 32'h0, 0, 0, 32'h1, -1);
            chk("align_no_strobe", 32'(st_cyc), 32'(t0));
            chk("align_err", 32'(rsp_err_o), 32'd1);
            txn(1, 32'h200, 4'h0, 32'h9, 0, 0, 32'h1, -1);
            chk("align_ben0_err", 32'(rsp_err_o), 32'd1);
            txn(0, 32'h208, 4'hF, 32'h0, 0, 0, 32'h2468ACE0, -1);
            chk("align_ticket_adv", 32'(last_tkt), 32'd4);
        end

        chk("never_ticket0", 32'(saw_zero), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cellrv32_dmem_bridge.md
Name: cellrv32_dmem_bridge

Overview:
- Upstream request stage between the CPU load/store data bus and the processor-internal DMEM.
- Accepts one valid/ready request at a time and issues a single-cycle rden/wren strobe with a unique 4-bit ticket.
- Waits for the ticket-matched ack/err, returns a one-cycle response, and converts a missing acknowledge into a bus error after a timeout.

Parameters:
- TIMEOUT, 16, cycles spent in WAIT without a matching ack/err before a timeout error; legal range ≥2.
- ADDR_W, 32, request/DMEM address width.

Ports:
- clk_i  in  1  global clock
- rstn_i  in  1  reset
- req_valid_i  in  1  CPU request valid
- req_ready_o  out  1  bridge can accept request
- req_we_i  in  1  1=write, 0=read
- req_addr_i  in  ADDR_W  byte address
- req_ben_i  in  4  byte enables
- req_wdata_i  in  32  write data
- rsp_valid_o  out  1  response pulse
- rsp_data_o  out  32  read data (0 for writes/errors)
- rsp_err_o  out  1  response error
- dmem_rden_o  out  1  DMEM read strobe
- dmem_wren_o  out  1  DMEM write strobe
- dmem_ben_o  out  4  DMEM byte enables
- dmem_addr_o  out  ADDR_W  DMEM address
- dmem_data_o  out  32  DMEM write data
- dmem_ticket_o  out  4  request ticket
- dmem_data_i  in  32  DMEM read data
- dmem_ticket_i  in  4  response ticket
- dmem_ack_i  in  1  DMEM acknowledge
- dmem_err_i  in  1  DMEM error

Clock and reset (already decided):
- Single clock clk_i.
- Reset rstn_i is asynchronous, active-low.

Behaviour:
- Reset values:
  - state = IDLE; req_ready_o = 1.
  - rsp_valid_o, rsp_err_o, dmem_rden_o, dmem_wren_o = 0.
  - dmem_ben_o = 0; dmem_data_o, dmem_addr_o, rsp_data_o = 0.
  - Ticket counter = 1; timeout counter = 0.
  - Assertion of rstn_i mid-operation aborts the transaction immediately. No response is generated, and any later DMEM ack is ignored.
- IDLE:
  - req_ready_o = 1; it is low in every other state.
  - On req_valid_i=1, capture we/addr/ben/wdata and go to ISSUE.
- ISSUE (exactly one cycle):
  - Assert dmem_rden_o = ~we or dmem_wren_o = we.
  - Drive dmem_ben_o, dmem_addr_o and dmem_data_o (write data for writes, 0 for reads) together with the current ticket on dmem_ticket_o.
  - Clear the timeout counter and go to WAIT.
- WAIT:
  - A match is (dmem_ack_i | dmem_err_i) with dmem_ticket_i == current ticket. On a match:
    - Latch rsp_err_o = dmem_err_i; if both ack and err are high, err wins.
    - Latch rsp_data_o = dmem_data_i for a read without error; otherwise 0.
    - Go to RESP.
  - A non-matching ack/err (stale ticket) is ignored.
  - The timeout counter increments each WAIT cycle without a match. When it reaches TIMEOUT-1 with no match, go to RESP with rsp_err_o=1 and rsp_data_o=0.
  - A match in that same cycle takes priority over the timeout.
- RESP:
  - rsp_valid_o=1 for exactly one cycle.
  - Advance the ticket: 1→2→…→15→1. Value 0 is never issued, since DMEM returns ticket 0 when not selected.
  - Go to IDLE.
  - rsp_data_o/rsp_err_o hold their values until the next response is latched.
- Strobes are high only in ISSUE. Outside ISSUE, dmem_ben_o and dmem_data_o are 0 and dmem_addr_o holds its last value.
- Nominal latency:
  - Request accepted at edge 0.
  - Strobe in cycle 1; DMEM ack sampled in cycle 2.
  - rsp_valid_o in cycle 3.
  - Peak throughput is 1 transaction / 4 cycles.
- Inputs in IDLE while req_valid_i=0 have no effect.

Optional Feature:
- Macro: CELLRV32_DMEM_BRIDGE_ALIGN_CHK_EN.
- Defined: at acceptance, the bridge checks the ben/addr[1:0] pair. Legal combinations:
  - Byte: ben = 0001<<addr[1:0].
  - Half: ben = 0011 with addr[1:0]=00, or ben = 1100 with addr[1:0]=10.
  - Word: ben = 1111 with addr[1:0]=00.
- Defined, illegal pair (including ben=0): skip ISSUE/WAIT and go directly to RESP with rsp_err_o=1 and rsp_data_o=0. No DMEM strobe is issued and the ticket still advances.
- Undefined: no check; ben/addr are passed through unchanged.

Test Plan:
- Read, addr 0x0000_0010, ben 1111, DMEM returns 0xDEADBEEF with ack and ticket 1 one cycle after the strobe → rsp_valid_o in cycle 3 with data 0xDEADBEEF, err 0; next ticket is 2.
- Write, addr 0x0000_0020, ben 0011, wdata 0x1234_5678 → dmem_wren_o pulses once with ben 0011 and data 0x1234_5678; response data 0, err 0.
- DMEM never acks, TIMEOUT=16 → rsp_valid_o with err=1 and data 0 exactly 16 WAIT cycles after the strobe; the next request is accepted in the following IDLE cycle.
- Stale ack with ticket 5 arrives during WAIT for ticket 6 → ignored; a later ack with ticket 6 completes the transaction normally. 16 back-to-back transactions → tickets run 1..15 then 1, never 0.
- Reset asserted in WAIT → all outputs zero immediately; a later ack produces no rsp_valid_o. With the ALIGN_CHK macro defined, a word access at addr 0x…02 with ben 1111 → err response, no strobe.
